// File: rtl/branch_target_unit.sv
// branch_target_unit
//   Registered branch/jump target generator for the Otter core. Computes the
//   BRANCH/JAL target (pc+imm), the JALR target ((rs1+imm) with bit 0 cleared)
//   and the link address (pc+4), flags IALIGN misalignment, and presents all
//   results one clock after an op is accepted.
//
//   Optional return-address stack, built only when the macro
//   BRANCH_TARGET_UNIT_RAS_EN is defined. It predicts JALR return targets and
//   flags mispredictions; without the macro the ras_* outputs are tied to 0.
//
// Ports
//   clk, rst        core clock, asynchronous active-high reset
//   flush           synchronous clear of the output stage and RAS occupancy
//   valid_in, op    op qualifier and opcode (00 BRANCH, 01 JAL, 10 JALR, 11 NONE)
//   pc, rs1, imm    instruction PC, JALR base register, sign-extended immediate
//   link_rd         rd is x1/x5
//   link_rs1        rs1 is x1/x5
//   rd_eq_rs1       rd and rs1 name the same register
//   target          registered target address
//   link_addr       registered pc+4
//   target_valid    one-cycle pulse per accepted op
//   misaligned      target violates IALIGN (meaningful with target_valid)
//   ras_pred        registered prediction popped from the RAS
//   ras_pred_valid  a pop from a non-empty RAS happened
//   ras_mispredict  ras_pred_valid and ras_pred differs from target
module branch_target_unit #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4,
  parameter int IALIGN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic            link_rd,
  input  logic            link_rs1,
  input  logic            rd_eq_rs1,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link_addr,
  output logic            target_valid,
  output logic            misaligned,
  output logic [XLEN-1:0] ras_pred,
  output logic            ras_pred_valid,
  output logic            ras_mispredict
);

  typedef enum logic [1:0] {
    OP_BRANCH = 2'b00,
    OP_JAL    = 2'b01,
    OP_JALR   = 2'b10,
    OP_NONE   = 2'b11
  } op_e;

  logic            accept;
  logic [XLEN-1:0] pc_sum;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] next_target;
  logic [XLEN-1:0] next_link;
  logic            next_misaligned;

  // flush outranks valid_in, so a flushed op is simply never accepted
  assign accept      = valid_in && (op != OP_NONE) && !flush;
  assign pc_sum      = pc + imm;
  assign jalr_sum    = rs1 + imm;
  assign next_target = (op == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_sum;
  assign next_link   = pc + XLEN'(4);

  // With 16-bit alignment only bit 0 matters, and JALR has already cleared it
  assign next_misaligned = (IALIGN == 16) ? next_target[0] : |next_target[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target       <= '0;
      link_addr    <= '0;
      target_valid <= 1'b0;
      misaligned   <= 1'b0;
    end else if (accept) begin
      target       <= next_target;
      link_addr    <= next_link;
      target_valid <= 1'b1;
      misaligned   <= next_misaligned;
    end else begin
      target_valid <= 1'b0;
      misaligned   <= 1'b0;
    end
  end

`ifdef BRANCH_TARGET_UNIT_RAS_EN
  localparam int            PW       = $clog2(RAS_DEPTH);
  localparam logic [PW:0]   RAS_FULL = (PW+1)'(RAS_DEPTH);

  // ptr addresses the next free slot; the top of stack lives at ptr-1
  logic [XLEN-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   top_idx;
  logic [PW:0]     count;
  logic            is_jump;
  logic            push_req;
  logic            pop_req;
  logic            non_empty;
  logic            pop_ok;

  // Every linking JAL/JALR pushes; a JALR whose rs1 is a link register pops
  // unless rd is that same register (then it is a plain push)
  assign is_jump   = (op == OP_JAL) || (op == OP_JALR);
  assign push_req  = accept && is_jump && link_rd;
  assign pop_req   = accept && (op == OP_JALR) && link_rs1 && !(link_rd && rd_eq_rs1);
  assign non_empty = (count != '0);
  assign pop_ok    = pop_req && non_empty;
  assign top_idx   = ptr - PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
      ptr            <= '0;
      count          <= '0;
      ras_pred       <= '0;
      ras_pred_valid <= 1'b0;
      ras_mispredict <= 1'b0;
    end else if (flush) begin
      count          <= '0;
      ras_pred_valid <= 1'b0;
      ras_mispredict <= 1'b0;
    end else begin
      ras_pred_valid <= pop_ok;
      ras_mispredict <= pop_ok && (stack[top_idx] != next_target);
      if (pop_ok) ras_pred <= stack[top_idx];

      // Pop+push on a non-empty stack replaces the top in place; a pop on an
      // empty stack degenerates to a plain push
      if (pop_ok && push_req) begin
        stack[top_idx] <= next_link;
      end else if (pop_ok) begin
        ptr   <= top_idx;
        count <= count - 1'b1;
      end else if (push_req) begin
        stack[ptr] <= next_link;
        ptr        <= ptr + PW'(1);
        if (count != RAS_FULL) count <= count + 1'b1;
      end
    end
  end
`else
  logic unused_ras;
  assign unused_ras     = ^{link_rd, link_rs1, rd_eq_rs1, (RAS_DEPTH > 0)};
  assign ras_pred       = '0;
  assign ras_pred_valid = 1'b0;
  assign ras_mispredict = 1'b0;
`endif

endmodule

// File: tb/tb_branch_target_unit.sv
module tb_branch_target_unit;

  localparam int XLEN      = 32;
  localparam int RAS_DEPTH = 4;
  localparam int IALIGN    = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            valid_in = 1'b0;
  logic [1:0]      op = 2'b11;
  logic [XLEN-1:0] pc = '0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] imm = '0;
  logic            link_rd = 1'b0;
  logic            link_rs1 = 1'b0;
  logic            rd_eq_rs1 = 1'b0;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link_addr;
  logic            target_valid;
  logic            misaligned;
  logic [XLEN-1:0] ras_pred;
  logic            ras_pred_valid;
  logic            ras_mispredict;

  branch_target_unit #(
    .XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH), .IALIGN(IALIGN)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .op(op),
    .pc(pc), .rs1(rs1), .imm(imm), .link_rd(link_rd), .link_rs1(link_rs1),
    .rd_eq_rs1(rd_eq_rs1), .target(target), .link_addr(link_addr),
    .target_valid(target_valid), .misaligned(misaligned), .ras_pred(ras_pred),
    .ras_pred_valid(ras_pred_valid), .ras_mispredict(ras_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            tv;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] lnk;
    logic            mis;
    logic            rpv;
    logic [XLEN-1:0] rp;
    logic            rmis;
  } exp_t;

  exp_t            scoreboard[$];
  logic [XLEN-1:0] ras_model[$];
  logic [XLEN-1:0] m_tgt = '0;
  logic [XLEN-1:0] m_lnk = '0;
  int              vectors = 0;
  int              miscompares = 0;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, predict the registered result, then compare
  task automatic applyStimulus(input logic v, input logic [1:0] o,
                               input logic [XLEN-1:0] p, input logic [XLEN-1:0] r,
                               input logic [XLEN-1:0] i, input logic lrd,
                               input logic lrs1, input logic req, input logic fl,
                               input string tag);
    exp_t            e;
    logic [XLEN-1:0] t;
    logic            acc;
    logic            pop_req;
    logic            push_req;
    @(negedge clk);
    valid_in = v; op = o; pc = p; rs1 = r; imm = i;
    link_rd = lrd; link_rs1 = lrs1; rd_eq_rs1 = req; flush = fl;

    acc = v && (o != 2'b11) && !fl;
    e.rpv = 1'b0; e.rp = '0; e.rmis = 1'b0; e.mis = 1'b0; e.tv = 1'b0;
    if (fl) begin
      ras_model.delete();
    end else if (acc) begin
      if (o == 2'b10) begin
        t = r + i;
        t[0] = 1'b0;
      end else begin
        t = p + i;
      end
      m_tgt = t;
      m_lnk = p + 32'd4;
      e.tv  = 1'b1;
      e.mis = (IALIGN == 16) ? t[0] : (t[1:0] != 2'b00);
`ifdef BRANCH_TARGET_UNIT_RAS_EN
      push_req = (o == 2'b01 || o == 2'b10) && lrd;
      pop_req  = (o == 2'b10) && lrs1 && !(lrd && req);
      if (pop_req && ras_model.size() > 0) begin
        e.rp   = ras_model.pop_back();
        e.rpv  = 1'b1;
        e.rmis = (e.rp != t);
      end
      if (push_req) begin
        ras_model.push_back(p + 32'd4);
        if (ras_model.size() > RAS_DEPTH) void'(ras_model.pop_front());
      end
`else
      push_req = 1'b0;
      pop_req  = 1'b0;
`endif
    end
    e.tgt = m_tgt;
    e.lnk = m_lnk;
    scoreboard.push_back(e);

    @(posedge clk);
    #1;
    e = scoreboard.pop_front();
    checkOutput({tag, ".target_valid"}, XLEN'(target_valid), XLEN'(e.tv));
    checkOutput({tag, ".target"}, target, e.tgt);
    checkOutput({tag, ".link_addr"}, link_addr, e.lnk);
    if (e.tv) checkOutput({tag, ".misaligned"}, XLEN'(misaligned), XLEN'(e.mis));
    checkOutput({tag, ".ras_pred_valid"}, XLEN'(ras_pred_valid), XLEN'(e.rpv));
    checkOutput({tag, ".ras_mispredict"}, XLEN'(ras_mispredict), XLEN'(e.rmis));
    if (e.rpv) checkOutput({tag, ".ras_pred"}, ras_pred, e.rp);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".target"}, target, '0);
    checkOutput({tag, ".link_addr"}, link_addr, '0);
    checkOutput({tag, ".target_valid"}, XLEN'(target_valid), '0);
    checkOutput({tag, ".misaligned"}, XLEN'(misaligned), '0);
    checkOutput({tag, ".ras_pred"}, ras_pred, '0);
    checkOutput({tag, ".ras_pred_valid"}, XLEN'(ras_pred_valid), '0);
    checkOutput({tag, ".ras_mispredict"}, XLEN'(ras_mispredict), '0);
  endtask

  initial begin
    #3;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Arithmetic and alignment
    applyStimulus(1, 2'b00, 32'h100, 32'h0, 32'hFFFF_FFF8, 0, 0, 0, 0, "branch");
    applyStimulus(1, 2'b10, 32'h0, 32'h2003, 32'h0, 0, 0, 0, 0, "jalr_align");
    applyStimulus(1, 2'b01, 32'h1000, 32'h0, 32'h6, 0, 0, 0, 0, "jal_mis");

    // Idle cycles hold target/link
    applyStimulus(0, 2'b00, 32'h5555, 32'h0, 32'h4, 0, 0, 0, 0, "idle_v0");
    applyStimulus(1, 2'b11, 32'h7777, 32'h0, 32'h4, 0, 0, 0, 0, "idle_none");

    // Call / return
    applyStimulus(1, 2'b01, 32'h40, 32'h0, 32'h200, 1, 0, 0, 0, "call1");
    applyStimulus(1, 2'b10, 32'h300, 32'h44, 32'h0, 0, 1, 0, 0, "ret_hit");
    applyStimulus(1, 2'b01, 32'h40, 32'h0, 32'h200, 1, 0, 0, 0, "call2");
    applyStimulus(1, 2'b10, 32'h300, 32'h48, 32'h0, 0, 1, 0, 0, "ret_miss");

    // Overflow: five pushes into four entries, then five pops
    for (int k = 1; k <= 5; k++)
      applyStimulus(1, 2'b01, 32'(k) << 8, 32'h0, 32'h1000, 1, 0, 0, 0, "ovf_push");
    for (int k = 0; k < 5; k++)
      applyStimulus(1, 2'b10, 32'h900, 32'h504, 32'h0, 0, 1, 0, 0, "ovf_pop");

    // Pop-then-push replaces the top; rd==rs1 is a plain push
    applyStimulus(1, 2'b10, 32'h700, 32'h10, 32'h0, 1, 1, 0, 0, "popush_empty");
    applyStimulus(1, 2'b01, 32'h600, 32'h0, 32'h40, 1, 0, 0, 0, "popush_call");
    applyStimulus(1, 2'b10, 32'h800, 32'h604, 32'h0, 1, 1, 0, 0, "popush");
    applyStimulus(1, 2'b10, 32'h880, 32'h20, 32'h0, 1, 1, 1, 0, "same_reg_push");
    applyStimulus(1, 2'b10, 32'h900, 32'h884, 32'h0, 0, 1, 0, 0, "pop_a");
    applyStimulus(1, 2'b10, 32'h900, 32'h804, 32'h0, 0, 1, 0, 0, "pop_b");
    applyStimulus(1, 2'b00, 32'h900, 32'h0, 32'h8, 1, 1, 0, 0, "branch_noras");

    // Flush beats a valid JAL and empties the RAS
    applyStimulus(1, 2'b01, 32'hA00, 32'h0, 32'h10, 1, 0, 0, 0, "pre_flush");
    applyStimulus(1, 2'b01, 32'hB00, 32'h0, 32'h10, 1, 0, 0, 1, "flush");
    applyStimulus(1, 2'b10, 32'hC00, 32'hA04, 32'h0, 0, 1, 0, 0, "pop_after_flush");

    // Back-to-back mixed traffic
    for (int k = 0; k < 40; k++)
      applyStimulus(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                    $urandom, $urandom, $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), "b2b");

    // Asynchronous reset mid-stream
    applyStimulus(1, 2'b01, 32'hD00, 32'h0, 32'h24, 1, 0, 0, 0, "pre_reset");
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    ras_model.delete();
    m_tgt = '0;
    m_lnk = '0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 2'b10, 32'hE00, 32'hD04, 32'h0, 0, 1, 0, 0, "pop_after_reset");
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, "idle_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_target_unit.md
Name: branch_target_unit

Overview:
- Parametrised, registered successor to the combinational branch/jump address adder.
- Computes BRANCH, JAL and JALR targets for XLEN-wide PCs, with link-address generation, misalignment detection and a one-cycle registered output stage.
- Optionally includes a return-address stack (RAS) that predicts JALR return targets and flags RAS mispredictions.
- Sits between decode/register-read and the PC-select mux of the Otter core.

Parameters:
- XLEN, 32, datapath width of PC, rs1, immediate and target.
- RAS_DEPTH, 4, RAS entries; power of two, at least 2.
- IALIGN, 32, instruction alignment in bits: 32 checks target[1:0], 16 checks target[0].

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of the output stage and the RAS.
- valid_in  in  1  the op/operands are valid this cycle.
- op  in  2  00 BRANCH, 01 JAL, 10 JALR, 11 NONE.
- pc  in  XLEN  PC of the instruction.
- rs1  in  XLEN  rs1 operand, used by JALR only.
- imm  in  XLEN  sign-extended immediate, already selected for the op.
- link_rd  in  1  rd is x1 or x5.
- link_rs1  in  1  rs1 is x1 or x5.
- rd_eq_rs1  in  1  rd and rs1 are the same register.
- target  out  XLEN  registered computed target.
- link_addr  out  XLEN  registered pc+4.
- target_valid  out  1  target/link_addr valid, one pulse per accepted op.
- misaligned  out  1  target violates IALIGN; qualified by target_valid.
- ras_pred  out  XLEN  registered RAS prediction for the popped entry.
- ras_pred_valid  out  1  a RAS pop with a non-empty stack occurred.
- ras_mispredict  out  1  ras_pred_valid and ras_pred != target.

Behaviour:
- Target arithmetic (modulo 2^XLEN, wrap-around ignored, no overflow flag):
  - BRANCH and JAL: pc+imm.
  - JALR: (rs1+imm) with bit 0 cleared.
  - link_addr: pc+4 for every op.
- Latency: exactly 1 cycle. Op accepted when valid_in=1 and op!=NONE; outputs register on the next rising edge. No back-pressure; a new op may be accepted every cycle.
- target_valid:
  - Goes to 1 in the cycle after an accepted op.
  - Is 0 in the cycle after valid_in=0, op=NONE, or flush=1.
  - target and link_addr hold their last value when target_valid=0.
- misaligned:
  - IALIGN=32: misaligned = |target[1:0].
  - IALIGN=16: misaligned = target[0], which is always 0 for JALR.
- Reset: all outputs 0. RAS pointer, count and entries are 0. Reset may assert mid-operation; the pending result is discarded.
- flush:
  - Has priority over valid_in.
  - Clears target_valid, ras_pred_valid and ras_mispredict next cycle.
  - Clears RAS count; entries need not be cleared.
- RAS actions, evaluated only for an accepted JAL or JALR:
  - JAL or JALR with link_rd=1 and link_rs1=0: PUSH pc+4.
  - JALR with link_rd=0 and link_rs1=1: POP.
  - JALR with link_rd=1, link_rs1=1, rd_eq_rs1=0: POP then PUSH pc+4 (same cycle). Prediction is the popped value; the new top is pc+4; count is unchanged when non-empty, and becomes 1 when empty.
  - JALR with link_rd=1, link_rs1=1, rd_eq_rs1=1: PUSH only.
  - BRANCH: no RAS effect.
- RAS boundaries:
  - PUSH when full: circular overwrite of the oldest entry; count stays at RAS_DEPTH.
  - POP when empty: ras_pred_valid=0; pointer and count unchanged.
  - Pointer wraps modulo RAS_DEPTH.
- ras_pred, ras_pred_valid and ras_mispredict register in the same cycle as target. ras_pred_valid is 0 for any op without a successful pop.

Optional Feature:
- Macro: BRANCH_TARGET_UNIT_RAS_EN.
- Defined: the RAS and its prediction/mispredict logic are built as described above.
- Undefined: no RAS storage. ras_pred, ras_pred_valid and ras_mispredict are tied to 0. RAS_DEPTH is ignored. All target and link behaviour is identical.

Test Plan:
- Target arithmetic: BRANCH pc=0x100, imm=0xFFFFFFF8 -> next cycle target=0xF8, link_addr=0x104, target_valid=1, misaligned=0.
- JALR alignment: rs1=0x2003, imm=0 -> target=0x2002. With IALIGN=32, misaligned=1. With IALIGN=16, misaligned=0.
- Call/return (RAS_EN):
  - JAL pc=0x40, link_rd=1 pushes 0x44.
  - JALR link_rs1=1, rs1=0x44, imm=0 -> ras_pred=0x44, ras_pred_valid=1, ras_mispredict=0.
  - Repeating with rs1=0x48 -> ras_mispredict=1.
- RAS overflow (RAS_DEPTH=4): 5 pushes of 0x104, 0x204, 0x304, 0x404, 0x504, then 5 pops -> preds 0x504, 0x404, 0x304, 0x204, then ras_pred_valid=0 on the 5th pop.
- Flush and reset:
  - flush=1 together with a valid JAL -> target_valid=0 next cycle; a subsequent pop gives ras_pred_valid=0.
  - rst asserted mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
- Idle and back-to-back: op=NONE or valid_in=0 -> target_valid=0 with target held. Back-to-back ops on consecutive cycles -> one valid result per cycle, in order.
